// File: rtl/bp_profile_pkg.sv
// Shared types for the stall profiler and its snapshot streamer: reason
// enumeration, streamer FSM states and the stream header layout.
package bp_profile_pkg;

  localparam int bp_stall_reason_num_lp = 24;

  // Enum value k selects counter k in the profiler's counter bank.
  typedef enum logic [4:0] {
    e_ic_miss, e_ic_tl_miss, e_ic_fence, e_br_mispredict,
    e_target_mispredict, e_dir_mispredict, e_fe_cmd, e_fe_queue_stall,
    e_branch_override, e_ret_override, e_dc_miss, e_dc_tl_miss,
    e_dc_fence, e_long_haul, e_control_haz, e_data_haz,
    e_aux_dep, e_load_dep, e_mul_dep, e_fma_dep,
    e_sb_full, e_exception, e_eret, e_unknown
  } bp_stall_reason_e;

  typedef logic [bp_stall_reason_num_lp-1:0] bp_stall_reason_s;

  typedef enum logic [1:0] {e_idle, e_hdr, e_cnt} bp_streamer_state_e;

  typedef struct packed {
    logic [7:0]  magic;
    logic [7:0]  count;
    logic [15:0] seq;
  } bp_stream_header_s;

  localparam logic [7:0] bp_stream_magic_gp = 8'hA5;

endpackage

// File: rtl/bp_profile_period_timer.sv
// Free-running sample-period timer. Fires trig_o on the last cycle of each
// period; held by freeze_i or a zero period.
module bp_profile_period_timer #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               freeze_i,
  input  logic [width_p-1:0] period_i,
  output logic               trig_o
);

  logic [width_p-1:0] timer_r;
  logic [width_p-1:0] last_count;
  logic               active;

  assign last_count = period_i - width_p'(1);
  assign active     = (period_i != '0) && !freeze_i;
  assign trig_o     = active && (timer_r == last_count);

  // Lowering period_i below the running count lands in the '>' case and
  // clears without firing, since trig_o only decodes equality.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      timer_r <= '0;
    end else if (active) begin
      if (timer_r >= last_count) timer_r <= '0;
      else                       timer_r <= timer_r + width_p'(1);
    end
  end

endmodule

// File: rtl/bp_stall_profile_streamer.sv
// Snapshots the stall counter bank on a timer or host trigger and streams a
// header plus one word per reason over valid/ready.
module bp_stall_profile_streamer
  import bp_profile_pkg::*;
#(
  parameter int num_reasons_p  = 24,
  parameter int cnt_width_p    = 32,
  parameter int period_width_p = 32
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 freeze_i,
  input  logic [num_reasons_p*cnt_width_p-1:0] stall_cnt_i,
  input  logic [period_width_p-1:0]            period_i,
  input  logic                                 snapshot_req_i,
  output logic [cnt_width_p-1:0]               data_o,
  output logic                                 v_o,
  input  logic                                 ready_i,
  output logic                                 busy_o,
  output logic [15:0]                          seq_o,
  output logic [15:0]                          dropped_o
);

  localparam int idx_width_lp = (num_reasons_p > 1) ? $clog2(num_reasons_p) : 1;
  localparam logic [idx_width_lp-1:0] idx_last_lp = idx_width_lp'(num_reasons_p - 1);

  bp_streamer_state_e       state_r;
  logic [idx_width_lp-1:0]  idx_r;
  logic [cnt_width_p-1:0]   shadow_r [num_reasons_p];
  logic                     trig_timer;
  logic                     trigger;
  logic                     capture;
  logic                     drop_event;
  bp_stream_header_s        header;

  bp_profile_period_timer #(.width_p(period_width_p)) period_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .freeze_i (freeze_i),
    .period_i (period_i),
    .trig_o   (trig_timer)
  );

  assign trigger    = (trig_timer | snapshot_req_i) & ~freeze_i;
  assign capture    = trigger && (state_r == e_idle);
  assign drop_event = (trigger && (state_r != e_idle)) || (freeze_i && snapshot_req_i);
  assign header     = '{magic: bp_stream_magic_gp, count: 8'(num_reasons_p), seq: seq_o};

  // NOTE: shadow regs carry no reset; they are only observable after a capture
  // has overwritten every entry, so a reset would only add fanout on reset_i.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      for (int k = 0; k < num_reasons_p; k++)
        shadow_r[k] <= stall_cnt_i[k*cnt_width_p +: cnt_width_p];
    end
  end

  // NOTE: every output word decodes registered state only, so ready_i never
  // reaches v_o or data_o combinationally; the default keeps this latch-free.
  always_comb begin
    data_o = '0;
    case (state_r)
      e_hdr:   data_o = cnt_width_p'(header);
      e_cnt:   data_o = shadow_r[idx_r];
      default: data_o = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= e_idle;
      idx_r     <= '0;
      v_o       <= 1'b0;
      busy_o    <= 1'b0;
      seq_o     <= '0;
      dropped_o <= '0;
    end else begin
      if (drop_event && (dropped_o != 16'hFFFF))
        dropped_o <= dropped_o + 16'd1;

      case (state_r)
        e_idle: if (trigger) begin
          state_r <= e_hdr;
          v_o     <= 1'b1;
          busy_o  <= 1'b1;
        end
        e_hdr: if (ready_i) begin
          state_r <= e_cnt;
          idx_r   <= '0;
        end
        e_cnt: if (ready_i) begin
          if (idx_r == idx_last_lp) begin
            state_r <= e_idle;
            v_o     <= 1'b0;
            busy_o  <= 1'b0;
            seq_o   <= seq_o + 16'd1;
          end else begin
            idx_r <= idx_r + idx_width_lp'(1);
          end
        end
        default: state_r <= e_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_stall_profile_streamer.sv
// Directed and randomized checks of the snapshot streamer against a queue
// model: a trigger in idle enqueues the whole expected stream.
module tb_bp_stall_profile_streamer;

  localparam int nr = 24;
  localparam int cw = 32;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              freeze_i;
  logic [nr*cw-1:0]  stall_cnt_i;
  logic [31:0]       period_i;
  logic              snapshot_req_i;
  logic [cw-1:0]     data_o;
  logic              v_o;
  logic              ready_i;
  logic              busy_o;
  logic [15:0]       seq_o;
  logic [15:0]       dropped_o;

  bp_stall_profile_streamer dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .freeze_i       (freeze_i),
    .stall_cnt_i    (stall_cnt_i),
    .period_i       (period_i),
    .snapshot_req_i (snapshot_req_i),
    .data_o         (data_o),
    .v_o            (v_o),
    .ready_i        (ready_i),
    .busy_o         (busy_o),
    .seq_o          (seq_o),
    .dropped_o      (dropped_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model: the pending stream as a queue of words.
  logic [31:0] m_q[$];
  longint      m_timer   = 0;
  int          m_seq     = 0;
  int          m_dropped = 0;
  bit          prev_v     = 0;
  bit          prev_ready = 0;
  bit          prev_rst   = 1;
  logic [31:0] prev_data  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_counts_ramp();
    for (int k = 0; k < nr; k++) stall_cnt_i[k*cw +: cw] = 32'(k * 3);
  endtask

  task automatic set_counts_random();
    for (int k = 0; k < nr; k++) stall_cnt_i[k*cw +: cw] = $urandom;
  endtask

  // Compare outputs against the model, advance the model with the current
  // inputs, then clock once and settle.
  task automatic step();
    bit idle, hs, trig_t, trig;
    check("v_o", {31'd0, v_o}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) check("data_o", data_o, m_q[0]);
    check("busy_o", {31'd0, busy_o}, {31'd0, m_q.size() != 0});
    check("seq_o", {16'd0, seq_o}, 32'(m_seq & 16'hFFFF));
    check("dropped_o", {16'd0, dropped_o}, 32'(m_dropped));
    if (!prev_rst && prev_v && !prev_ready) begin
      check("hold_v", {31'd0, v_o}, 32'd1);
      check("hold_data", data_o, prev_data);
    end

    prev_v = v_o; prev_ready = ready_i; prev_data = data_o; prev_rst = reset_i;
    if (reset_i) begin
      m_q.delete(); m_timer = 0; m_seq = 0; m_dropped = 0;
    end else begin
      idle   = (m_q.size() == 0);
      hs     = !idle && ready_i;
      trig_t = (period_i != 0) && !freeze_i && (m_timer == longint'(period_i) - 1);
      trig   = (trig_t || snapshot_req_i) && !freeze_i;
      if (trig && idle) begin
        m_q.push_back(32'hA5000000 | (32'(nr) << 16) | 32'(m_seq & 16'hFFFF));
        for (int k = 0; k < nr; k++) m_q.push_back(stall_cnt_i[k*cw +: cw]);
      end else if (trig || (freeze_i && snapshot_req_i)) begin
        if (m_dropped < 65535) m_dropped++;
      end
      if (hs) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_seq++;
      end
      if (period_i != 0 && !freeze_i) begin
        if (m_timer >= longint'(period_i) - 1) m_timer = 0;
        else                                   m_timer++;
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; snapshot_req_i = 1'b0; freeze_i = 1'b0;
    step();
    reset_i = 1'b0;
  endtask

  initial begin
    int n;
    reset_i = 1'b1; freeze_i = 1'b0; period_i = '0; snapshot_req_i = 1'b0;
    ready_i = 1'b1; stall_cnt_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_v", {31'd0, v_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_seq", {16'd0, seq_o}, 32'd0);
    check("rst_dropped", {16'd0, dropped_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    reset_i = 1'b0;

    // T1: single request, ramp counters, ready held high.
    set_counts_ramp();
    snapshot_req_i = 1'b1; step(); snapshot_req_i = 1'b0;
    check("t1_header", data_o, 32'hA5180000);
    step();
    check("t1_word0", data_o, 32'd0);
    repeat (23) step();
    check("t1_last", data_o, 32'd69);
    repeat (4) step();
    check("t1_seq", {16'd0, seq_o}, 32'd1);

    // T2: periodic sampling every 100 cycles.
    period_i = 32'd100;
    do_reset();
    for (int c = 0; c < 330; c++) begin
      if (c % 7 == 0) set_counts_random();
      step();
    end
    check("t2_seq", {16'd0, seq_o}, 32'd3);
    check("t2_dropped", {16'd0, dropped_o}, 32'd0);
    period_i = '0;

    // T3: random back-pressure, live counters changing every cycle.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_counts_random();
      ready_i        = $urandom_range(0, 1) == 1;
      snapshot_req_i = $urandom_range(0, 39) == 0;
      step();
    end
    snapshot_req_i = 1'b0; ready_i = 1'b1;
    repeat (30) step();

    // T4: stalled sink, extra requests while busy are dropped.
    do_reset();
    ready_i = 1'b0;
    snapshot_req_i = 1'b1; step(); snapshot_req_i = 1'b0;
    for (int p = 0; p < 3; p++) begin
      step();
      snapshot_req_i = 1'b1; step(); snapshot_req_i = 1'b0;
    end
    step();
    check("t4_dropped", {16'd0, dropped_o}, 32'd3);
    check("t4_header", data_o, 32'hA5180000);
    ready_i = 1'b1;
    repeat (30) step();
    check("t4_seq", {16'd0, seq_o}, 32'd1);

    // T5: freeze holds the timer; trigger lands after the remaining count.
    period_i = 32'd10;
    do_reset();
    repeat (5) step();
    freeze_i = 1'b1;
    for (int c = 0; c < 50; c++) begin
      snapshot_req_i = (c == 20);
      step();
    end
    snapshot_req_i = 1'b0;
    check("t5_frozen_v", {31'd0, v_o}, 32'd0);
    check("t5_dropped", {16'd0, dropped_o}, 32'd1);
    freeze_i = 1'b0;
    n = 0;
    while (!v_o && n < 20) begin
      step();
      n++;
    end
    check("t5_resume_cycles", 32'(n), 32'd5);
    period_i = '0;
    repeat (30) step();

    // T6: reset in the middle of a stream.
    do_reset();
    set_counts_ramp();
    snapshot_req_i = 1'b1; step(); snapshot_req_i = 1'b0;
    repeat (5) step();
    check("t6_cnt4", data_o, 32'd12);
    reset_i = 1'b1; step(); reset_i = 1'b0;
    check("t6_v", {31'd0, v_o}, 32'd0);
    check("t6_busy", {31'd0, busy_o}, 32'd0);
    check("t6_seq", {16'd0, seq_o}, 32'd0);
    snapshot_req_i = 1'b1; step(); snapshot_req_i = 1'b0;
    check("t6_restart_header", data_o, 32'hA5180000);
    repeat (30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
